// File: rtl/data_bus_responder_pkg.sv
// Shared types and constants for the data-bus responder: FSM states, default window,
// legal byte-enable patterns and the wait-state counter width.
package data_bus_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RWAIT = 2'd1,
        WWAIT = 2'd2
    } state_t;

    localparam logic [31:0] DEF_ADDR_BASE = 32'h1001_0000;
    localparam int          WAIT_W        = 3;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Bytes may sit at any offset, halfwords only on even offsets, words only aligned.
    function automatic logic be_legal(input logic [3:0] be, input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        if (be == (BE_BYTE << a)) begin
            ok = 1'b1;
        end else if ((be == (BE_HALF << a)) && (a[0] == 1'b0)) begin
            ok = 1'b1;
        end else if ((be == BE_WORD) && (a == 2'b00)) begin
            ok = 1'b1;
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/data_bus_responder_bytelane_ram.sv
// Word-organised RAM built from four 8-bit lanes with per-lane write enables and a
// synchronous read port that returns the pre-write contents; no reset on the arrays.
module data_bus_responder_bytelane_ram #(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             i_clk,
    input  logic [IDX_W-1:0] i_addr,
    input  logic [3:0]       i_we,
    input  logic [31:0]      i_wdata,
    input  logic             i_re,
    output logic [31:0]      o_rdata
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        logic [7:0] r_q;

        // Lane write and read-before-write capture on the same edge.
        always_ff @(posedge i_clk) begin
            if (i_we[g]) begin
                r_mem[i_addr] <= i_wdata[8*g +: 8];
            end
            if (i_re) begin
                r_q <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = {g_lane[3].r_q, g_lane[2].r_q, g_lane[1].r_q, g_lane[0].r_q};

endmodule

// File: rtl/data_bus_responder.sv
// Memory-side responder for the CPU data bus: window decode, byte-lane RAM, wait states.
// Optional build macro MISALIGN_CHECK_EN rejects byte-enable/offset combinations that are not natural.
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = DEF_ADDR_BASE,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          READ_WAIT   = 0,
    parameter int          WRITE_WAIT  = 0
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [31:0] iAddress,
    input  logic [31:0] iWriteData,
    input  logic        iWriteEnable,
    input  logic        iReadEnable,
    input  logic [3:0]  iByteEnable,
    output logic [31:0] oReadData,
    output logic        oReady,
    output logic        oHit,
    output logic        oError
);

    localparam int                IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [32:0]       WIN_END = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);
    localparam logic [WAIT_W-1:0] RD_N    = WAIT_W'(READ_WAIT);
    localparam logic [WAIT_W-1:0] WR_N    = WAIT_W'(WRITE_WAIT);

    state_t            r_state;
    state_t            w_state_nx;
    logic [WAIT_W-1:0] r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic              r_ready;
    logic              r_error;
    logic              r_rd_valid;

    logic              w_hit;
    logic [IDX_W-1:0]  w_idx;
    logic              w_idle;
    logic              w_last;
    logic              w_wr_bad;
    logic              w_rd_bad;
    logic              w_acc_wr;
    logic              w_acc_rd;
    logic              w_reject;
    logic [IDX_W-1:0]  w_ram_addr;
    logic [3:0]        w_ram_we;
    logic [31:0]       w_ram_wdata;
    logic              w_ram_re;
    logic [31:0]       w_ram_q;

    // 33-bit compare keeps a window ending at 2^32 from wrapping.
    assign w_hit  = ({1'b0, iAddress} >= {1'b0, ADDR_BASE}) && ({1'b0, iAddress} < WIN_END);
    assign w_idx  = IDX_W'((iAddress - ADDR_BASE) >> 2);
    assign w_idle = (r_state == IDLE);
    assign w_last = (r_cnt <= WAIT_W'(1));

`ifdef MISALIGN_CHECK_EN
    assign w_wr_bad = !be_legal(iByteEnable, iAddress[1:0]);
    assign w_rd_bad = (iAddress[1:0] != 2'b00) && (iByteEnable == BE_WORD);
`else
    assign w_wr_bad = 1'b0;
    assign w_rd_bad = 1'b0;
`endif

    // A simultaneous read+write is served as a write but still flagged.
    assign w_acc_wr = w_idle && w_hit && iWriteEnable && !w_wr_bad;
    assign w_acc_rd = w_idle && w_hit && iReadEnable && !iWriteEnable && !w_rd_bad;
    assign w_reject = w_idle && (iWriteEnable || iReadEnable) &&
                      (!w_hit || (iWriteEnable && iReadEnable) ||
                       (iWriteEnable && w_wr_bad) || (!iWriteEnable && w_rd_bad));

    // FSM state register.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next-state decode.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (w_acc_wr && (WR_N != WAIT_W'(0))) begin
                    w_state_nx = WWAIT;
                end else if (w_acc_rd && (RD_N != WAIT_W'(0))) begin
                    w_state_nx = RWAIT;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            RWAIT, WWAIT: begin
                w_state_nx = w_last ? IDLE : r_state;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // FSM outputs: RAM port controls for immediate and deferred accesses.
    always_comb begin
        w_ram_addr  = w_idx;
        w_ram_wdata = iWriteData;
        w_ram_we    = 4'b0000;
        w_ram_re    = 1'b0;
        case (r_state)
            IDLE: begin
                w_ram_addr  = w_idx;
                w_ram_wdata = iWriteData;
                w_ram_we    = (w_acc_wr && (WR_N == WAIT_W'(0))) ? iByteEnable : 4'b0000;
                w_ram_re    = w_acc_rd && (RD_N == WAIT_W'(0));
            end
            RWAIT: begin
                w_ram_addr  = r_idx;
                w_ram_wdata = r_wdata;
                w_ram_we    = 4'b0000;
                w_ram_re    = w_last;
            end
            WWAIT: begin
                w_ram_addr  = r_idx;
                w_ram_wdata = r_wdata;
                w_ram_we    = w_last ? r_be : 4'b0000;
                w_ram_re    = 1'b0;
            end
            default: begin
                w_ram_addr  = w_idx;
                w_ram_wdata = iWriteData;
                w_ram_we    = 4'b0000;
                w_ram_re    = 1'b0;
            end
        endcase
    end

    // Request latch, wait counter and registered status outputs.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_cnt      <= WAIT_W'(0);
            r_idx      <= IDX_W'(0);
            r_wdata    <= 32'h0000_0000;
            r_be       <= 4'b0000;
            r_ready    <= 1'b1;
            r_error    <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_ready <= (w_state_nx == IDLE);
            r_error <= w_reject;
            if (w_ram_re) begin
                r_rd_valid <= 1'b1;
            end
            if (w_acc_wr || w_acc_rd) begin
                r_idx   <= w_idx;
                r_wdata <= iWriteData;
                r_be    <= iByteEnable;
                r_cnt   <= w_acc_wr ? WR_N : RD_N;
            end else if (r_cnt != WAIT_W'(0)) begin
                r_cnt <= r_cnt - WAIT_W'(1);
            end
        end
    end

    data_bus_responder_bytelane_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .i_clk   (iCLK),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .o_rdata (w_ram_q)
    );

    // The RAM output register has no reset, so it is masked until the first completed read.
    assign oReadData = r_rd_valid ? w_ram_q : 32'h0000_0000;
    assign oReady    = r_ready;
    assign oHit      = w_hit;
    assign oError    = r_error;

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench: one zero-wait responder and one with READ_WAIT=3 / WRITE_WAIT=2.
module tb_data_bus_responder;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we0, re0, we1, re1;
    logic [31:0] rdata0, rdata1;
    logic        rdy0, rdy1, hit0, hit1, err0, err1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q [$];
    logic [31:0] mdl [int];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    data_bus_responder dut0 (
        .iCLK(clk), .iRST(rst), .iAddress(addr), .iWriteData(wdata),
        .iWriteEnable(we0), .iReadEnable(re0), .iByteEnable(be),
        .oReadData(rdata0), .oReady(rdy0), .oHit(hit0), .oError(err0)
    );

    data_bus_responder #(.READ_WAIT(3), .WRITE_WAIT(2)) dut1 (
        .iCLK(clk), .iRST(rst), .iAddress(addr), .iWriteData(wdata),
        .iWriteEnable(we1), .iReadEnable(re1), .iByteEnable(be),
        .oReadData(rdata1), .oReady(rdy1), .oHit(hit1), .oError(err1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && ({1'b0, a} < ({1'b0, BASE} + 33'd4096));
    endfunction

    function automatic bit wr_ok(input logic [3:0] m, input logic [31:0] a);
`ifdef MISALIGN_CHECK_EN
        case (a[1:0])
            2'd0:    return (m == 4'b0001) || (m == 4'b0011) || (m == 4'b1111);
            2'd1:    return (m == 4'b0010);
            2'd2:    return (m == 4'b0100) || (m == 4'b1100);
            default: return (m == 4'b1000);
        endcase
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit rd_ok(input logic [3:0] m, input logic [31:0] a);
`ifdef MISALIGN_CHECK_EN
        return !((a[1:0] != 2'b00) && (m == 4'b1111));
`else
        return 1'b1;
`endif
    endfunction

    function automatic int key(input int sel, input logic [31:0] a);
        return sel * 65536 + int'((a - BASE) >> 2);
    endfunction

    function automatic logic out_rdy(input int sel);
        return (sel == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic out_err(input int sel);
        return (sel == 0) ? err0 : err1;
    endfunction

    function automatic logic [31:0] out_rdata(input int sel);
        return (sel == 0) ? rdata0 : rdata1;
    endfunction

    task automatic drive(input int sel, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        addr  = a;
        wdata = d;
        be    = m;
        we0   = (sel == 0) && w;
        re0   = (sel == 0) && r;
        we1   = (sel == 1) && w;
        re1   = (sel == 1) && r;
        @(posedge clk);
        #1;
        we0 = 1'b0; re0 = 1'b0; we1 = 1'b0; re1 = 1'b0;
    endtask

    // One bus transaction: predict, drive, then check error, wait length and read data.
    task automatic op(input int sel, input logic w, input logic r,
                      input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                      input string tag);
        bit          exp_err, acc_w, acc_r;
        int          exp_lows, lows;
        logic [31:0] old;
        exp_err  = (w || r) && (!in_win(a) || (w && r) || (w ? !wr_ok(m, a) : !rd_ok(m, a)));
        acc_w    = w && in_win(a) && wr_ok(m, a);
        acc_r    = r && !w && in_win(a) && rd_ok(m, a);
        exp_lows = acc_w ? (sel == 1 ? 2 : 0) : (acc_r ? (sel == 1 ? 3 : 0) : 0);
        if (acc_w) begin
            old = mdl.exists(key(sel, a)) ? mdl[key(sel, a)] : 32'h0000_0000;
            for (int i = 0; i < 4; i++) begin
                if (m[i]) old[8*i +: 8] = d[8*i +: 8];
            end
            mdl[key(sel, a)] = old;
        end
        if (acc_r) begin
            sb_q.push_back(mdl[key(sel, a)]);
            last_rd[sel] = mdl[key(sel, a)];
        end
        drive(sel, w, r, a, d, m);
        @(negedge clk);
        check_eq({tag, "_err"}, 32'(out_err(sel)), 32'(exp_err));
        lows = 0;
        while (!out_rdy(sel) && lows < 20) begin
            lows++;
            @(negedge clk);
        end
        check_eq({tag, "_wait"}, 32'(lows), 32'(exp_lows));
        if (acc_r) begin
            check_eq({tag, "_rdata"}, out_rdata(sel), sb_q.pop_front());
        end else begin
            check_eq({tag, "_hold"}, out_rdata(sel), last_rd[sel]);
        end
        if (exp_err) begin
            @(negedge clk);
            check_eq({tag, "_errpulse"}, 32'(out_err(sel)), 32'd0);
        end
    endtask

    initial begin
        int lows;
        rst = 1'b1;
        addr = 32'h0; wdata = 32'h0; be = 4'b0000;
        we0 = 1'b0; re0 = 1'b0; we1 = 1'b0; re1 = 1'b0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        repeat (2) @(negedge clk);
        check_eq("rst_rdy0", 32'(rdy0), 32'd1);
        check_eq("rst_rdata0", rdata0, 32'h0);
        check_eq("rst_err0", 32'(err0), 32'd0);
        check_eq("rst_rdy1", 32'(rdy1), 32'd1);
        check_eq("rst_rdata1", rdata1, 32'h0);
        check_eq("rst_err1", 32'(err1), 32'd0);
        rst = 1'b0;

        op(0, 1'b1, 1'b0, BASE, 32'hDEAD_BEEF, 4'b1111, "wr_word");
        op(0, 1'b0, 1'b1, BASE, 32'h0, 4'b1111, "rd_word");
        op(0, 1'b1, 1'b0, BASE, 32'h1111_1111, 4'b1111, "wr_ones");
        op(0, 1'b1, 1'b0, BASE + 32'd1, 32'h0000_AA00, 4'b0010, "wr_lane1");
        op(0, 1'b0, 1'b1, BASE, 32'h0, 4'b1111, "rd_lane1");
        op(0, 1'b1, 1'b0, BASE, 32'hFFFF_FFFF, 4'b0000, "wr_be0");
        op(0, 1'b0, 1'b1, BASE, 32'h0, 4'b1111, "rd_be0");

        // Window edges and a miss.
        for (int i = 0; i < 4; i++) begin
            logic [31:0] probe [4];
            probe[0] = BASE + 32'd4092; probe[1] = BASE + 32'd4096;
            probe[2] = BASE - 32'd1;    probe[3] = 32'h0040_0000;
            @(negedge clk);
            addr = probe[i];
            #1;
            check_eq("hit", 32'(hit0), 32'(in_win(probe[i])));
        end
        op(0, 1'b0, 1'b1, 32'h0040_0000, 32'h0, 4'b1111, "rd_miss");
        op(0, 1'b1, 1'b0, BASE + 32'd4096, 32'h7777_7777, 4'b1111, "wr_miss");
        op(0, 1'b0, 1'b1, BASE, 32'h0, 4'b1111, "rd_after_miss");
        op(0, 1'b1, 1'b1, BASE + 32'd12, 32'h1234_5678, 4'b1111, "wr_both");
        op(0, 1'b0, 1'b1, BASE + 32'd12, 32'h0, 4'b1111, "rd_both");
        op(0, 1'b1, 1'b0, BASE + 32'd2, 32'hCAFE_F00D, 4'b1111, "wr_misal");
        op(0, 1'b0, 1'b1, BASE, 32'h0, 4'b1111, "rd_misal");

        // Wait-state responder: write, then a read with a request injected during the wait.
        op(1, 1'b1, 1'b0, BASE + 32'd4, 32'hA5A5_5A5A, 4'b1111, "w_wr");
        sb_q.push_back(mdl[key(1, BASE + 32'd4)]);
        last_rd[1] = mdl[key(1, BASE + 32'd4)];
        drive(1, 1'b0, 1'b1, BASE + 32'd4, 32'h0, 4'b1111);
        wdata = 32'hBAD0_BAD0;
        we1   = 1'b1;
        lows  = 0;
        @(negedge clk);
        while (!rdy1 && lows < 20) begin
            lows++;
            if (lows == 2) we1 = 1'b0;
            @(negedge clk);
        end
        we1 = 1'b0;
        check_eq("w_rd_wait", 32'(lows), 32'd3);
        check_eq("w_rd_rdata", rdata1, sb_q.pop_front());
        op(1, 1'b0, 1'b1, BASE + 32'd4, 32'h0, 4'b1111, "w_rd_again");

        // Reset during the second write wait cycle aborts the write.
        op(1, 1'b1, 1'b0, BASE + 32'd8, 32'h5555_AAAA, 4'b1111, "w_wr8");
        op(1, 1'b0, 1'b1, BASE + 32'd4, 32'h0, 4'b1111, "w_rd4");
        drive(1, 1'b1, 1'b0, BASE + 32'd8, 32'h0BAD_F00D, 4'b1111);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_rdy", 32'(rdy1), 32'd1);
        check_eq("abort_rdata", rdata1, 32'h0);
        check_eq("abort_err", 32'(err1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        op(1, 1'b0, 1'b1, BASE + 32'd8, 32'h0, 4'b1111, "abort_keep");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Memory-side responder for the processor data bus driven by the multicycle datapath: address, write data, read/write enables and byte enables.
- Decodes an address window and holds a word-organised RAM with per-byte write lanes.
- Returns registered read data and inserts a programmable number of wait states, signalled on oReady.
- Sits between the CPU data-bus master and the data segment; it is the reader/writer counterpart of the datapath's bus initiator.

Parameters:
ADDR_BASE, 32'h1001_0000, first byte address of the decoded window.
DEPTH_WORDS, 1024, number of 32-bit words; power of two, 16..16384.
READ_WAIT, 0, extra wait cycles on reads (0..7).
WRITE_WAIT, 0, extra wait cycles on writes (0..7).

Ports:
iCLK  in  1  system clock; all state updates on its rising edge.
iRST  in  1  reset, asynchronous, active-high.
iAddress  in  32  byte address from the initiator.
iWriteData  in  32  write data, already lane-aligned by the initiator.
iWriteEnable  in  1  write request.
iReadEnable  in  1  read request.
iByteEnable  in  4  byte-lane write mask; bit n selects data[8n+7:8n].
oReadData  out  32  registered read data.
oReady  out  1  high when idle or when the current access completes this cycle.
oHit  out  1  combinational: iAddress is inside the window.
oError  out  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset: one clock (iCLK); reset asynchronous, active-high (iRST). On reset, state=IDLE, oReadData=0, oReady=1, oError=0. Any pending write is dropped. RAM contents are not cleared.
- Decode: hit = ADDR_BASE <= iAddress < ADDR_BASE+4*DEPTH_WORDS, using a 33-bit compare so the window end cannot wrap. Word index = (iAddress-ADDR_BASE)[log2(DEPTH_WORDS)+1:2]. iAddress[1:0] is ignored unless MISALIGN_CHECK_EN is defined.
- FSM states: IDLE, RWAIT, WWAIT.
- A request is accepted only in IDLE. Address, data and byte enables are latched at the accepting edge; the initiator need not hold them afterwards.
- Read, READ_WAIT=0: at the accepting edge, oReadData <= mem[idx]. Data is valid the next cycle and oReady stays 1, so single-cycle capture by the CPU's data register works.
- Read, READ_WAIT=N>0: go to RWAIT; oReady=0 for N cycles; data is loaded on the final edge; oReady=1 in the cycle after, then return to IDLE.
- oReadData holds its value until the next completed read. Writes never change it.
- Write, WRITE_WAIT=0: enabled lanes are written at the accepting edge; oReady stays 1.
- Write, WRITE_WAIT=N>0: go to WWAIT; oReady=0 for N cycles; lanes are committed on the final edge.
- iByteEnable=0000 on a write: completes with normal timing and changes nothing.
- Both enables asserted: the access is treated as a write, the read is ignored, oError pulses.
- Miss (oHit=0) with any enable: no RAM access, oReadData is unchanged, oReady stays 1, oError pulses one cycle.
- Read of a word being written in the same cycle returns the old value (read-before-write).
- Requests arriving while oReady=0 are ignored. The initiator must hold or reissue them.
- Wait-state counter is 3 bits; it loads N at acceptance and counts down to 0 without wrapping.
- Reset mid-RWAIT/WWAIT: abort, return to IDLE, no RAM write.

Optional Feature:
MISALIGN_CHECK_EN
- Defined: a write is rejected (no RAM change, oError pulse, normal oReady) unless iByteEnable is legal for iAddress[1:0]:
  - 0001<<a, for any a;
  - 0011<<a, for a in {0,2};
  - 1111, for a=0 only.
- Defined: a read with iAddress[1:0]!=0 and iByteEnable=1111 is also rejected.
- Not defined: low address bits are ignored and any mask is accepted.

Decomposition:
- Shared package: FSM state enum (IDLE/RWAIT/WWAIT), default ADDR_BASE, the legal byte-enable pattern constants, and the wait-counter width.
- Sub-module bytelane_ram: four 8-bit-wide DEPTH_WORDS arrays, per-lane write enable, synchronous read-before-write port, no reset.
- The FSM, decode and error logic stay in data_bus_responder.

Test Plan:
- Write 32'hDEADBEEF at 32'h1001_0000 with BE 1111, then read the same address (READ_WAIT=0) -> oReadData=32'hDEADBEEF one cycle after the read, oReady never low.
- Write 32'h0000_AA00 with BE 0010 at 32'h1001_0001 over 32'h1111_1111 -> read returns 32'h1111_AA11.
- READ_WAIT=3: read 32'h1001_0004 -> oReady low for exactly 3 cycles, data valid with oReady=1, a request during the wait is ignored.
- Read 32'h0040_0000 (miss) -> oHit=0, one oError pulse, oReadData unchanged, RAM untouched.
- WRITE_WAIT=2, assert iRST in the second wait cycle -> oReady=1, oReadData=0, target word keeps its old value.
- MISALIGN_CHECK_EN: BE 1111 at 32'h1001_0002 -> oError pulse, no write; without the macro the same write updates word 32'h1001_0000.
